ice40_himax_frame_buf_ctrl: RTL and testbench

Ping-pong frame buffer controller directly downstream of the 64×64 Himax video process stage. Accepts its per-line planar write stream (R/G/B planes, 16-bit offset samples) into one of two banks. Answers its ready/done frame handshake, and hands complete frames to the ML engine through a bank-valid/release handshake with a 1-cycle read port. Camera capture and ML inference then overlap: one bank fills while the other is read.

---
 rtl/himax_fb_pkg.sv | 23 ++
 rtl/himax_fb_dpram.sv | 35 +++
 rtl/ice40_himax_frame_buf_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ice40_himax_frame_buf_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/himax_fb_pkg.sv
// Shared definitions for the Himax ping-pong frame buffer: bank-state
// encoding, colour-plane numbering and the plane-valid limit.
package himax_fb_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  localparam logic [3:0] PLANE_R     = 4'd0;
  localparam logic [3:0] PLANE_G     = 4'd1;
  localparam logic [3:0] PLANE_B     = 4'd2;
  // First plane number that is not stored; writes at or above it are dropped.
  localparam logic [3:0] PLANE_LIMIT = PLANE_B + 4'd1;

  // A bank may accept camera writes only while it is empty or filling.
  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/himax_fb_dpram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// Behavioural model; on silicon it maps onto SPRAM/EBR blocks.
module himax_fb_dpram #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Store incoming samples; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; output holds its last value when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= {DW{1'b0}};
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ice40_himax_frame_buf_ctrl.sv
// Ping-pong frame buffer controller between the Himax video process stage
// and the ML engine. One bank fills from the camera while the other is read.
// Optional statistics counters are enabled by defining ICE40_HIMAX_FB_STATS_EN.
module ice40_himax_frame_buf_ctrl
  import himax_fb_pkg::*;
#(
  parameter int PLANE_AW = 12,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_we,
  input  logic [15:0]   i_waddr,
  input  logic [DW-1:0] i_din,
  input  logic          i_rd_done,
  output logic          o_rd_rdy,
  output logic          o_ml_frame_vld,
  output logic          o_ml_bank,
  input  logic          i_ml_re,
  input  logic [13:0]   i_ml_raddr,
  output logic [DW-1:0] o_ml_rdata,
  output logic          o_ml_rvld,
  input  logic          i_ml_release,
  output logic [15:0]   o_frame_cnt,
  output logic [7:0]    o_drop_cnt
);

  localparam int MEM_AW = PLANE_AW + 3;

  bank_state_t st [0:1];
  bank_state_t st_n [0:1];
  logic wbank, wbank_n;
  logic rbank, rbank_n;
  logic frame_vld, frame_vld_n;
  logic rd_rdy;
  logic done_prev, done_pulse;
  logic rvld;

  logic [3:0] plane;
  logic       plane_ok, we_ok, done_apply, rel_apply, re_ok;

  assign plane      = i_waddr[15:12];
  assign plane_ok   = (plane < PLANE_LIMIT);
  assign we_ok      = i_we & rd_rdy & plane_ok;
  assign done_apply = done_pulse & bank_writable(st[wbank]);
  assign rel_apply  = i_ml_release & frame_vld;
  assign re_ok      = i_ml_re & frame_vld;

  // Bank states, pointers and handshakes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st[0]     <= BANK_EMPTY;
      st[1]     <= BANK_EMPTY;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      frame_vld <= 1'b0;
      rd_rdy    <= 1'b0;
      done_prev <= 1'b0;
      done_pulse <= 1'b0;
      rvld      <= 1'b0;
    end else begin
      st[0]     <= st_n[0];
      st[1]     <= st_n[1];
      wbank     <= wbank_n;
      rbank     <= rbank_n;
      frame_vld <= frame_vld_n;
      // Drop for at least one cycle on frame done so the producer clears done.
      rd_rdy    <= done_apply ? 1'b0 : bank_writable(st[wbank]);
      done_prev <= i_rd_done;
      done_pulse <= i_rd_done & ~done_prev;
      rvld      <= re_ok;
    end
  end

  // Next bank states: fill, frame done, release, read arbitration, pointer move.
  always_comb begin
    st_n[0]     = st[0];
    st_n[1]     = st[1];
    wbank_n     = wbank;
    rbank_n     = rbank;
    frame_vld_n = frame_vld;

    if (we_ok && (st[wbank] == BANK_EMPTY)) begin
      st_n[wbank] = BANK_FILLING;
    end else begin
      st_n[wbank] = st_n[wbank];
    end

    // A done with no writes still closes a (blank) frame.
    if (done_apply) begin
      st_n[wbank] = BANK_FULL;
    end else begin
      st_n[wbank] = st_n[wbank];
    end

    if (rel_apply) begin
      st_n[rbank] = BANK_EMPTY;
      frame_vld_n = 1'b0;
    end else if (!frame_vld) begin
      if ((st[0] == BANK_FULL) && (st[1] == BANK_FULL)) begin
        // Older frame is the one not under the write pointer.
        rbank_n      = ~wbank;
        st_n[~wbank] = BANK_READING;
        frame_vld_n  = 1'b1;
      end else if (st[0] == BANK_FULL) begin
        rbank_n     = 1'b0;
        st_n[0]     = BANK_READING;
        frame_vld_n = 1'b1;
      end else if (st[1] == BANK_FULL) begin
        rbank_n     = 1'b1;
        st_n[1]     = BANK_READING;
        frame_vld_n = 1'b1;
      end else begin
        frame_vld_n = 1'b0;
      end
    end else begin
      frame_vld_n = frame_vld;
    end

    // Move the write pointer onto a free bank once its own bank is closed.
    if (!bank_writable(st_n[wbank]) && (st_n[~wbank] == BANK_EMPTY)) begin
      wbank_n = ~wbank;
    end else begin
      wbank_n = wbank;
    end
  end

  himax_fb_dpram #(.AW(MEM_AW), .DW(DW)) u_mem (
    .clk    (clk),
    .resetn (resetn),
    .we     (we_ok),
    .waddr  ({wbank, plane[1:0], i_waddr[PLANE_AW-1:0]}),
    .wdata  (i_din),
    .re     (re_ok),
    .raddr  ({rbank, i_ml_raddr}),
    .rdata  (o_ml_rdata)
  );

  assign o_rd_rdy       = rd_rdy;
  assign o_ml_frame_vld = frame_vld;
  assign o_ml_bank      = rbank;
  assign o_ml_rvld      = rvld;

`ifdef ICE40_HIMAX_FB_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic        drop;

  assign drop = i_we & ~we_ok;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= 16'h0000;
      drop_cnt  <= 8'h00;
    end else begin
      if (done_apply && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign o_frame_cnt = frame_cnt;
  assign o_drop_cnt  = drop_cnt;
`else
  assign o_frame_cnt = 16'h0000;
  assign o_drop_cnt  = 8'h00;
`endif

endmodule

// File: tb/tb_ice40_himax_frame_buf_ctrl.sv
// Directed self-checking bench for ice40_himax_frame_buf_ctrl.
module tb_ice40_himax_frame_buf_ctrl;
  import himax_fb_pkg::*;

`ifdef ICE40_HIMAX_FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_we = 1'b0;
  logic [15:0] i_waddr = 16'h0000;
  logic [15:0] i_din = 16'h0000;
  logic        i_rd_done = 1'b0;
  logic        o_rd_rdy;
  logic        o_ml_frame_vld;
  logic        o_ml_bank;
  logic        i_ml_re = 1'b0;
  logic [13:0] i_ml_raddr = 14'h0000;
  logic [15:0] o_ml_rdata;
  logic        o_ml_rvld;
  logic        i_ml_release = 1'b0;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_drop_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_frames = 16'd0;
  logic [7:0]  exp_drops = 8'd0;

  ice40_himax_frame_buf_ctrl dut (
    .clk(clk), .resetn(resetn), .i_we(i_we), .i_waddr(i_waddr), .i_din(i_din),
    .i_rd_done(i_rd_done), .o_rd_rdy(o_rd_rdy), .o_ml_frame_vld(o_ml_frame_vld),
    .o_ml_bank(o_ml_bank), .i_ml_re(i_ml_re), .i_ml_raddr(i_ml_raddr),
    .o_ml_rdata(o_ml_rdata), .o_ml_rvld(o_ml_rvld), .i_ml_release(i_ml_release),
    .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    i_we = 1'b1; i_waddr = a; i_din = d;
    tick();
    i_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a);
    i_ml_re = 1'b1; i_ml_raddr = a;
    tick();
    i_ml_re = 1'b0;
  endtask

  // Raise done, drop it when rd_rdy falls, return cycles until frame valid (0 = timeout).
  task automatic done_wait_vld(output int lat);
    lat = 0;
    i_rd_done = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!o_rd_rdy) i_rd_done = 1'b0;
      if (o_ml_frame_vld) begin
        lat = c;
        break;
      end
    end
    i_rd_done = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    n_checks++;
    if (o_frame_cnt !== (STATS ? exp_frames : 16'd0)) begin
      n_fail++; $display("FAIL %s_frame_cnt: got %0d want %0d", tag, o_frame_cnt, STATS ? exp_frames : 16'd0);
    end
    n_checks++;
    if (o_drop_cnt !== (STATS ? exp_drops : 8'd0)) begin
      n_fail++; $display("FAIL %s_drop_cnt: got %0d want %0d", tag, o_drop_cnt, STATS ? exp_drops : 8'd0);
    end
  endtask

  task automatic check_all_reset(input string tag);
    n_checks++;
    if ({o_rd_rdy, o_ml_frame_vld, o_ml_bank, o_ml_rvld} !== 4'b0000) begin
      n_fail++; $display("FAIL %s_flags: got rdy=%0b vld=%0b bank=%0b rvld=%0b want 0000", tag, o_rd_rdy, o_ml_frame_vld, o_ml_bank, o_ml_rvld);
    end
    n_checks++;
    if (o_ml_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL %s_rdata: got %h want 0000", tag, o_ml_rdata);
    end
    n_checks++;
    if ({o_frame_cnt, o_drop_cnt} !== 24'h000000) begin
      n_fail++; $display("FAIL %s_counters: got %0d/%0d want 0/0", tag, o_frame_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    check_all_reset("in_reset");
    resetn = 1'b1;
    tick();
    n_checks++;
    if (o_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_after_reset: got %0b want 1", o_rd_rdy); end
    n_checks++;
    if (o_ml_frame_vld !== 1'b0) begin n_fail++; $display("FAIL vld_after_reset: got %0b want 0", o_ml_frame_vld); end
    check_counts("after_reset");
  endtask

  task automatic test_first_frame();
    int lat;
    wr({PLANE_R, 12'h003}, 16'h0003);
    wr({PLANE_G, 12'h005}, 16'h1005);
    wr({PLANE_B, 12'h007}, 16'h2007);
    n_checks++;
    if (o_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_while_filling: got %0b want 1", o_rd_rdy); end
    done_wait_vld(lat);
    exp_frames = 16'd1;
    n_checks++;
    if (lat < 1 || lat > 3) begin n_fail++; $display("FAIL first_vld_latency: got %0d want 1..3", lat); end
    n_checks++;
    if (o_ml_bank !== 1'b0) begin n_fail++; $display("FAIL first_bank: got %0b want 0", o_ml_bank); end
    check_counts("first_frame");
    rd(14'h1005);
    n_checks++;
    if (o_ml_rdata !== 16'h1005 || o_ml_rvld !== 1'b1) begin
      n_fail++; $display("FAIL read_1005: got %h rvld=%0b want 1005 rvld=1", o_ml_rdata, o_ml_rvld);
    end
    tick();
    n_checks++;
    if (o_ml_rvld !== 1'b0) begin n_fail++; $display("FAIL rvld_idle: got %0b want 0", o_ml_rvld); end
  endtask

  task automatic test_back_to_back();
    i_ml_re = 1'b1; i_ml_raddr = 14'h0003;
    tick();
    n_checks++;
    if (o_ml_rdata !== 16'h0003 || o_ml_rvld !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got %h rvld=%0b want 0003 rvld=1", o_ml_rdata, o_ml_rvld);
    end
    i_ml_raddr = 14'h2007;
    tick();
    i_ml_re = 1'b0;
    n_checks++;
    if (o_ml_rdata !== 16'h2007 || o_ml_rvld !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got %h rvld=%0b want 2007 rvld=1", o_ml_rdata, o_ml_rvld);
    end
  endtask

  task automatic test_two_frames();
    int drop_at;
    drop_at = 0;
    wr(16'h0005, 16'hB105);
    wr(16'h0006, 16'h2006);
    i_rd_done = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!o_rd_rdy) begin drop_at = c; break; end
    end
    i_rd_done = 1'b0;
    exp_frames = 16'd2;
    n_checks++;
    if (drop_at == 0) begin n_fail++; $display("FAIL second_done_rdy_drop: got no drop want drop"); end
    tick(); tick(); tick();
    n_checks++;
    if (o_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_held_low: got %0b want 0", o_rd_rdy); end
    n_checks++;
    if (o_ml_frame_vld !== 1'b1 || o_ml_bank !== 1'b0) begin
      n_fail++; $display("FAIL still_reading_bank0: got vld=%0b bank=%0b want 1/0", o_ml_frame_vld, o_ml_bank);
    end
    wr(16'h0006, 16'hDEAD);
    exp_drops = 8'd1;
    check_counts("two_frames");
    i_ml_release = 1'b1;
    tick();
    i_ml_release = 1'b0;
    n_checks++;
    if (o_ml_frame_vld !== 1'b0) begin n_fail++; $display("FAIL vld_after_release: got %0b want 0", o_ml_frame_vld); end
    tick();
    n_checks++;
    if (o_ml_frame_vld !== 1'b1 || o_ml_bank !== 1'b1 || o_rd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL switch_to_bank1: got vld=%0b bank=%0b rdy=%0b want 1/1/1", o_ml_frame_vld, o_ml_bank, o_rd_rdy);
    end
    rd(14'h0006);
    n_checks++;
    if (o_ml_rdata !== 16'h2006) begin n_fail++; $display("FAIL dropped_write_leaked: got %h want 2006", o_ml_rdata); end
    rd(14'h0005);
    n_checks++;
    if (o_ml_rdata !== 16'hB105) begin n_fail++; $display("FAIL bank1_read: got %h want b105", o_ml_rdata); end
  endtask

  task automatic test_plane_drop();
    wr(16'h3010, 16'hBEEF);
    exp_drops = 8'd2;
    check_counts("plane_drop");
    n_checks++;
    if (o_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_after_plane_drop: got %0b want 1", o_rd_rdy); end
  endtask

  task automatic test_same_cycle();
    int drop_at;
    wr(16'h0010, 16'hC010);
    i_rd_done = 1'b1;
    tick();
    i_ml_release = 1'b1;
    tick();
    i_ml_release = 1'b0;
    i_rd_done = 1'b0;
    exp_frames = 16'd3;
    n_checks++;
    if (o_rd_rdy !== 1'b0 || o_ml_frame_vld !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_mid: got rdy=%0b vld=%0b want 0/0", o_rd_rdy, o_ml_frame_vld);
    end
    tick();
    n_checks++;
    if (o_ml_frame_vld !== 1'b1 || o_ml_bank !== 1'b0 || o_rd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_result: got vld=%0b bank=%0b rdy=%0b want 1/0/1", o_ml_frame_vld, o_ml_bank, o_rd_rdy);
    end
    check_counts("same_cycle");
    rd(14'h0010);
    n_checks++;
    if (o_ml_rdata !== 16'hC010) begin n_fail++; $display("FAIL same_cycle_read: got %h want c010", o_ml_rdata); end
    rd(14'h3010);
    n_checks++;
    if (o_ml_rdata === 16'hBEEF) begin n_fail++; $display("FAIL plane3_written: got %h want not beef", o_ml_rdata); end
    // The released bank 1 is now the write bank: fill it and read it back.
    wr(16'h0020, 16'hD020);
    drop_at = 0;
    i_rd_done = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!o_rd_rdy) begin drop_at = c; break; end
    end
    i_rd_done = 1'b0;
    exp_frames = 16'd4;
    tick();
    n_checks++;
    if (drop_at == 0 || o_rd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL fourth_done_rdy: got drop_at=%0d rdy=%0b want drop and 0", drop_at, o_rd_rdy);
    end
    i_ml_release = 1'b1;
    tick();
    i_ml_release = 1'b0;
    tick();
    n_checks++;
    if (o_ml_frame_vld !== 1'b1 || o_ml_bank !== 1'b1) begin
      n_fail++; $display("FAIL fourth_frame_bank: got vld=%0b bank=%0b want 1/1", o_ml_frame_vld, o_ml_bank);
    end
    rd(14'h0020);
    n_checks++;
    if (o_ml_rdata !== 16'hD020) begin n_fail++; $display("FAIL fourth_frame_read: got %h want d020", o_ml_rdata); end
  endtask

  task automatic test_reset_mid();
    int lat;
    wr(16'h0001, 16'h7777);
    i_ml_re = 1'b1; i_ml_raddr = 14'h0020;
    tick();
    resetn = 1'b0;
    #1;
    check_all_reset("async_reset");
    i_ml_re = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    exp_frames = 16'd0;
    exp_drops = 8'd0;
    tick();
    n_checks++;
    if (o_rd_rdy !== 1'b1 || o_ml_frame_vld !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_flags: got rdy=%0b vld=%0b want 1/0", o_rd_rdy, o_ml_frame_vld);
    end
    check_counts("post_reset");
    rd(14'h0020);
    n_checks++;
    if (o_ml_rvld !== 1'b0) begin n_fail++; $display("FAIL read_without_frame: got rvld=%0b want 0", o_ml_rvld); end
    wr(16'h0001, 16'hE001);
    done_wait_vld(lat);
    exp_frames = 16'd1;
    n_checks++;
    if (lat < 1 || lat > 3 || o_ml_bank !== 1'b0) begin
      n_fail++; $display("FAIL bank0_reuse: got lat=%0d bank=%0b want 1..3/0", lat, o_ml_bank);
    end
    rd(14'h0001);
    n_checks++;
    if (o_ml_rdata !== 16'hE001) begin n_fail++; $display("FAIL bank0_reuse_read: got %h want e001", o_ml_rdata); end
    check_counts("reuse");
  endtask

  task automatic test_drop_saturate();
    for (int k = 0; k < 300; k++) begin
      wr(16'h3000, 16'h5A5A);
    end
    exp_drops = 8'hFF;
    check_counts("drop_saturate");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_two_frames();
    test_plane_drop();
    test_same_cycle();
    test_reset_mid();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
